// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, colours and 5x5 bitmaps for the sprite renderer
package sprite_pkg;

    typedef enum logic [1:0] {
        ORIENT_LEFT  = 2'b00,
        ORIENT_RIGHT = 2'b01,
        ORIENT_UP    = 2'b10,
        ORIENT_DOWN  = 2'b11
    } orient_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_DRAW,
        ST_DONE
    } state_t;

    localparam logic [2:0] COLOR_ERASE  = 3'b000;
    localparam logic [2:0] COLOR_PACMAN = 3'b110;
    localparam logic [2:0] COLOR_FRIGHT = 3'b111;

    // Row r occupies bits [r*5 +: 5]; bit 0 of each row is px=0.
    localparam logic [24:0] PAC_LEFT  = {5'b00111, 5'b00011, 5'b00111, 5'b11111, 5'b01111};
    localparam logic [24:0] PAC_RIGHT = {5'b11111, 5'b11110, 5'b11111, 5'b01111, 5'b00111};
    localparam logic [24:0] PAC_UP    = {5'b01110, 5'b11111, 5'b11111, 5'b11011, 5'b11011};
    localparam logic [24:0] PAC_DOWN  = {5'b11011, 5'b11011, 5'b11111, 5'b11111, 5'b01110};
    localparam logic [24:0] GHOST     = {5'b00000, 5'b01110, 5'b01110, 5'b01010, 5'b00100};

    function automatic logic [2:0] ghost_color(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            default: return 3'b110;
        endcase
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - combinational sprite bitmap lookup
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int PX_W  = 3,
    parameter int PY_W  = 3
) (
    input  logic [SEL_W-1:0] char_idx,
    input  logic [1:0]       orientation,
    input  logic [PY_W-1:0]  py,
    input  logic [PX_W-1:0]  px,
    output logic             pixel
);

    logic [24:0] bitmap;
    logic [4:0]  bit_idx;

    always_comb begin
        bitmap  = GHOST;
        pixel   = 1'b0;
        bit_idx = 5'(32'(py) * 5 + 32'(px));
        if (char_idx == '0) begin
            case (orient_t'(orientation))
                ORIENT_LEFT:  bitmap = PAC_LEFT;
                ORIENT_RIGHT: bitmap = PAC_RIGHT;
                ORIENT_UP:    bitmap = PAC_UP;
                default:      bitmap = PAC_DOWN;
            endcase
        end
        // Sprites larger than the 5x5 art draw nothing outside it.
        if (32'(px) < 5 && 32'(py) < 5)
            pixel = bitmap[bit_idx];
    end

endmodule

// File: rtl/sprite_render_engine.sv
// rtl/sprite_render_engine.sv - walks all characters once per start and streams their pixels to VGA
module sprite_render_engine
    import sprite_pkg::*;
#(
    parameter int NUM_CHARS = 5,
    parameter int SPRITE_W  = 5,
    parameter int SPRITE_H  = 5,
    parameter int CELL      = 7,
    parameter int ORIGIN    = 1,
    parameter int COORD_W   = 8,
    parameter int COLOR_W   = 3,
    localparam int SEL_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic               start,
    input  logic               erase,
    input  logic               frightened,
    input  logic [1:0]         pacman_orientation,
    output logic [SEL_W-1:0]   char_sel,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    input  logic               char_visible,
    output logic [COORD_W-1:0] vga_x,
    output logic [COORD_W-1:0] vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    localparam int PX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int PY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    state_t             state, state_nxt;
    logic [PX_W-1:0]    px;
    logic [PY_W-1:0]    py;
    logic [COORD_W-1:0] cx_q, cy_q;
    logic               vis_q, erase_q, fright_q;
    logic [1:0]         orient_q;
    logic               pix_bit;
    logic [2:0]         color_sel;
    logic               last_px, last_py, last_char;

    assign last_px   = (px == PX_W'(SPRITE_W - 1));
    assign last_py   = (py == PY_W'(SPRITE_H - 1));
    assign last_char = (char_sel == SEL_W'(NUM_CHARS - 1));
    assign busy      = (state == ST_LATCH) || (state == ST_DRAW);
    assign done      = (state == ST_DONE);

    sprite_rom #(
        .SEL_W(SEL_W),
        .PX_W (PX_W),
        .PY_W (PY_W)
    ) u_rom (
        .char_idx   (char_sel),
        .orientation(orient_q),
        .py         (py),
        .px         (px),
        .pixel      (pix_bit)
    );

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_DRAW;
            ST_DRAW:  if (last_px && last_py) state_nxt = last_char ? ST_DONE : ST_LATCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            char_sel <= '0;
            px       <= '0;
            py       <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            vis_q    <= 1'b0;
            erase_q  <= 1'b0;
            fright_q <= 1'b0;
            orient_q <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        erase_q  <= erase;
                        fright_q <= frightened;
                        orient_q <= pacman_orientation;
                    end
                end
                ST_LATCH: begin
                    cx_q  <= char_x;
                    cy_q  <= char_y;
                    vis_q <= char_visible;
                    px    <= '0;
                    py    <= '0;
                end
                ST_DRAW: begin
                    if (last_px) begin
                        px <= '0;
                        py <= py + 1'b1;
                        if (last_py && !last_char)
                            char_sel <= char_sel + 1'b1;
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                default: char_sel <= '0;
            endcase
        end
    end

    always_comb begin
        color_sel = COLOR_PACMAN;
        if (erase_q)
            color_sel = COLOR_ERASE;
        else if (char_sel != '0)
            color_sel = fright_q ? COLOR_FRIGHT : ghost_color(2'(char_sel - 1'b1));
    end

    // Pixel outputs trail the DRAW slot that produced them by one clock.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            if (state == ST_DRAW) begin
                vga_x     <= COORD_W'(cx_q * COORD_W'(CELL) + COORD_W'(px) + COORD_W'(ORIGIN));
                vga_y     <= COORD_W'(cy_q * COORD_W'(CELL) + COORD_W'(py) + COORD_W'(ORIGIN));
                vga_color <= COLOR_W'(color_sel);
                vga_plot  <= vis_q && (erase_q || pix_bit);
            end
        end
    end

endmodule

// File: tb/tb_sprite_render_engine.sv
// tb/tb_sprite_render_engine.sv - directed self-checking bench for sprite_render_engine
`timescale 1ns/1ps
module tb_sprite_render_engine;

    localparam logic [24:0] B_PAC_LEFT  = {5'b00111, 5'b00011, 5'b00111, 5'b11111, 5'b01111};
    localparam logic [24:0] B_PAC_RIGHT = {5'b11111, 5'b11110, 5'b11111, 5'b01111, 5'b00111};
    localparam logic [24:0] B_GHOST     = {5'b00000, 5'b01110, 5'b01110, 5'b01010, 5'b00100};

    logic       clock_50 = 1'b0;
    logic       reset, start, erase, frightened;
    logic [1:0] pacman_orientation;
    logic [2:0] char_sel;
    logic [7:0] char_x, char_y, vga_x, vga_y;
    logic       char_visible, vga_plot, busy, done;
    logic [2:0] vga_color;

    logic [7:0] cx_tab [5];
    logic [7:0] cy_tab [5];
    logic       vis_tab[5];

    int total = 0;
    int bad   = 0;

    int          n_plots, n_done, done_at, n_stray, n_badcol;
    int          cnt[5];
    logic [24:0] grid[5];
    logic        busy_first, busy_at_done, plot_at_done, seen_x0, seen_x255;

    always #5 clock_50 = ~clock_50;

    assign char_x       = (char_sel < 3'd5) ? cx_tab[char_sel]  : 8'd0;
    assign char_y       = (char_sel < 3'd5) ? cy_tab[char_sel]  : 8'd0;
    assign char_visible = (char_sel < 3'd5) ? vis_tab[char_sel] : 1'b0;

    sprite_render_engine dut (
        .clock_50          (clock_50),
        .reset             (reset),
        .start             (start),
        .erase             (erase),
        .frightened        (frightened),
        .pacman_orientation(pacman_orientation),
        .char_sel          (char_sel),
        .char_x            (char_x),
        .char_y            (char_y),
        .char_visible      (char_visible),
        .vga_x             (vga_x),
        .vga_y             (vga_y),
        .vga_color         (vga_color),
        .vga_plot          (vga_plot),
        .busy              (busy),
        .done              (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_color(input int k, input logic er, input logic fr);
        logic [2:0] pal[4];
        pal[0] = 3'b001; pal[1] = 3'b100; pal[2] = 3'b010; pal[3] = 3'b110;
        if (er)     return 3'b000;
        if (k == 0) return 3'b110;
        if (fr)     return 3'b111;
        return pal[(k - 1) % 4];
    endfunction

    function automatic int find_char(input logic [7:0] x, input logic [7:0] y,
                                     output int dxo, output int dyo);
        logic [7:0] dx, dy;
        dxo = 0;
        dyo = 0;
        for (int k = 0; k < 5; k++) begin
            dx = x - (cx_tab[k] * 8'd7 + 8'd1);
            dy = y - (cy_tab[k] * 8'd7 + 8'd1);
            if (dx < 8'd5 && dy < 8'd5) begin
                dxo = int'(dx);
                dyo = int'(dy);
                return k;
            end
        end
        return -1;
    endfunction

    task automatic run_pass(input logic er, input logic fr, input logic [1:0] ori,
                            input int mid_start, input int rst_at);
        int k, dx, dy;
        n_plots = 0; n_done = 0; done_at = -1; n_stray = 0; n_badcol = 0;
        busy_first = 0; busy_at_done = 1; plot_at_done = 0; seen_x0 = 0; seen_x255 = 0;
        for (int i = 0; i < 5; i++) begin
            cnt[i]  = 0;
            grid[i] = '0;
        end
        @(negedge clock_50);
        erase = er; frightened = fr; pacman_orientation = ori; start = 1'b1;
        @(posedge clock_50);
        #1 start = 1'b0;
        for (int n = 0; n < 180; n++) begin
            @(negedge clock_50);
            if (!reset) begin
                if (n == 0) busy_first = busy;
                if (done) begin
                    n_done++;
                    done_at      = n;
                    busy_at_done = busy;
                    plot_at_done = vga_plot;
                end
                if (vga_plot) begin
                    n_plots++;
                    k = find_char(vga_x, vga_y, dx, dy);
                    if (k < 0) begin
                        n_stray++;
                    end else begin
                        cnt[k]++;
                        grid[k][dy * 5 + dx] = 1'b1;
                        if (vga_color !== exp_color(k, er, fr)) n_badcol++;
                        if (k == 1 && vga_x == 8'd0)   seen_x0   = 1'b1;
                        if (k == 1 && vga_x == 8'd255) seen_x255 = 1'b1;
                    end
                end
            end
            if (n == mid_start) start = 1'b1;
            if (n == mid_start + 1) start = 1'b0;
            if (n == rst_at) begin
                reset = 1'b1;
                #1 check("rst_mid_async", {char_sel, vga_x, vga_y, vga_color, vga_plot, busy, done}, 32'd0);
            end
            if (n == rst_at + 1)
                check("rst_mid_next", {char_sel, vga_x, vga_y, vga_color, vga_plot, busy, done}, 32'd0);
            if (n == rst_at + 3) reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; erase = 1'b0; frightened = 1'b0; pacman_orientation = 2'b00;
        cx_tab[0] = 8'd2;  cy_tab[0] = 8'd3;
        cx_tab[1] = 8'd5;  cy_tab[1] = 8'd1;
        cx_tab[2] = 8'd8;  cy_tab[2] = 8'd2;
        cx_tab[3] = 8'd11; cy_tab[3] = 8'd4;
        cx_tab[4] = 8'd14; cy_tab[4] = 8'd5;
        for (int i = 0; i < 5; i++) vis_tab[i] = 1'b1;
        repeat (2) @(negedge clock_50);
        check("reset_state", {char_sel, vga_x, vga_y, vga_color, vga_plot, busy, done}, 32'd0);
        reset = 1'b0;

        run_pass(1'b0, 1'b0, 2'b00, -10, -10);
        check("t1_plots", n_plots, 53);
        check("t1_done_count", n_done, 1);
        check("t1_done_at", done_at, 130);
        check("t1_busy_after_start", busy_first, 1);
        check("t1_busy_in_done", busy_at_done, 0);
        check("t1_pac_grid", grid[0], B_PAC_LEFT);
        for (int i = 1; i < 5; i++) check("t1_ghost_grid", grid[i], B_GHOST);
        check("t1_stray", n_stray, 0);
        check("t1_colour", n_badcol, 0);

        run_pass(1'b0, 1'b0, 2'b01, -10, -10);
        check("t2_pac_grid", grid[0], B_PAC_RIGHT);
        check("t2_row_py2", grid[0][14:10], 5'b11111);
        check("t2_no_plot_15_25", grid[0][15], 0);
        check("t2_plots", n_plots, 57);
        check("t2_colour", n_badcol, 0);

        vis_tab[2] = 1'b0;
        run_pass(1'b1, 1'b0, 2'b00, -10, -10);
        check("t3_plots", n_plots, 100);
        check("t3_char2_box", cnt[2], 0);
        check("t3_colour0", n_badcol, 0);
        check("t3_full_box", grid[0], 25'h1ffffff);
        check("t3_plot_with_done", plot_at_done, 1);
        vis_tab[2] = 1'b1;

        run_pass(1'b0, 1'b1, 2'b00, -10, -10);
        check("t4_colour", n_badcol, 0);
        check("t4_plots", n_plots, 53);

        cx_tab[1] = 8'd36; cy_tab[1] = 8'd0;
        run_pass(1'b0, 1'b0, 2'b00, -10, -10);
        check("t5_wrap_count", cnt[1], 9);
        check("t5_wrap_grid", grid[1], B_GHOST);
        check("t5_seen_x255", seen_x255, 1);
        check("t5_seen_x0", seen_x0, 1);
        check("t5_stray", n_stray, 0);
        cx_tab[1] = 8'd5; cy_tab[1] = 8'd1;

        run_pass(1'b0, 1'b0, 2'b00, -10, 40);
        check("t6_no_done_after_reset", n_done, 0);

        run_pass(1'b0, 1'b0, 2'b00, 50, -10);
        check("t6_mid_start_done", n_done, 1);
        check("t6_mid_start_done_at", done_at, 130);
        check("t6_mid_start_plots", n_plots, 53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
